text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
//  Character-cell text buffer plus terminal writer that feeds the VGA text renderer.
//  - Accepts a byte stream (valid/ready).
//  - Interprets CR/LF/BS/FF and writes printable bytes at a hardware cursor.
//  - Scrolls the screen when the cursor passes the last row.
//  - Serves the renderer through a read-only port: 11-bit cell position in,
//    8-bit cell (bit7 = invert, bits6:0 = glyph) out, one cycle later.
// PARAMETERS
//  COLS       80     characters per row
//  ROWS       25     rows per screen; COLS*ROWS must be <= 2**ADDR_W
//  ADDR_W     11     cell address width; matches the renderer pos port
//  FILL_CHAR  8'h20  value written by every clear/scroll fill
// PORTS
//  clk         in   1       single clock; renderer and writer share it
//  rst_n       in   1       asynchronous, active-low reset
//  in_data     in   8       byte to interpret
//  in_valid    in   1       in_data valid
//  in_ready    out  1       block can accept a byte this cycle
//  rd_pos      in   ADDR_W  renderer cell address (row*COLS + col)
//  rd_char     out  8       RAM[rd_pos], registered one cycle after rd_pos
//  cursor_pos  out  ADDR_W  cur_row*COLS + cur_col, registered
// BEHAVIOUR
//  - Reset is asynchronous. While rst_n is low:
//    - cur_row = cur_col = 0; cursor_pos = 0; in_ready = 0.
//    - FSM goes to CLEAR_ALL with fill address 0.
//    - rd_char holds its value; RAM contents are not reset.
//  - FSM states:
//    - CLEAR_ALL: writes FILL_CHAR to cells 0..COLS*ROWS-1, one per cycle
//      (2000 cycles), then goes to IDLE.
//    - IDLE: in_ready = 1. A byte is accepted on any edge with in_valid & in_ready.
//    - SCROLL: for d = 0..(ROWS-1)*COLS-1, issue an internal read of cell d+COLS on
//      cycle k and write that data to cell d on cycle k+1. This takes 1921 cycles,
//      then goes to CLEAR_ROW.
//    - CLEAR_ROW: writes FILL_CHAR to the last row (80 cycles), then goes to IDLE.
//  - in_ready is 0 in every state except IDLE. A scroll holds in_ready low for
//    exactly 2001 cycles, starting the cycle after the triggering handshake.
//  - Byte decode on handshake:
//    - 0x20-0x7E and 0x80-0xFF (printable; bit7 stored as invert):
//      - Written to RAM[cursor] at the handshake edge; cur_col++.
//      - If cur_col was COLS-1: cur_col = 0 and a newline is performed.
//    - 0x0A LF: newline. 0x0D CR: cur_col = 0.
//    - 0x08 BS: if cur_col > 0 then cur_col--. Nothing is erased; no effect at col 0.
//    - 0x0C FF: cursor to 0,0, then CLEAR_ALL.
//    - All other bytes < 0x20, and 0x7F: consumed and ignored.
//  - Newline: cur_col = 0. If cur_row < ROWS-1 then cur_row++. Otherwise cur_row
//    stays ROWS-1 and the FSM goes to SCROLL.
//  - cursor_pos updates on the edge after the cursor changes. During SCROLL and
//    CLEAR it already shows the final cursor position.
//  - Display port:
//    - Always active and independent of the FSM.
//    - rd_pos >= COLS*ROWS returns don't-care.
//    - Same-cycle read and write of one address returns old data.
//  - Address arithmetic: row*COLS uses shifts and adds at ADDR_W bits, with no
//    multiplier. The cursor address is registered, so no mul sits in the write path.
//  - rst_n asserted mid-SCROLL or mid-CLEAR aborts the operation; after release the
//    block runs a full CLEAR_ALL.
// STRUCTURE
//  - Shared package vga_text_pkg holds:
//    - COLS, ROWS, ADDR_W, FILL_CHAR.
//    - Control-code constants: CH_LF, CH_CR, CH_BS, CH_FF.
//    - The FSM state enum (IDLE, CLEAR_ALL, SCROLL, CLEAR_ROW).
//  - Sub-module text_ram: 2**ADDR_W x 8 true dual-port RAM.
//    - Port A: read/write with a registered read, used by the FSM.
//    - Port B: read-only with a registered read, driving rd_char.
//    - Written as a single always block so it infers block RAM.
//  - Top level holds the FSM, the cursor registers and the fill/copy address counter.
// TESTING
//  1. Release reset. in_ready is low for 2000 cycles, then high. Reading rd_pos 0,
//     1999 and 1024 gives 8'h20 one cycle later.
//  2. Send "AB" (0x41, 0x42). Then rd_pos 0 -> 0x41, rd_pos 1 -> 0x42, cursor_pos = 2.
//     Send 0xC1: cell 2 = 0xC1 (inverted A).
//  3. Send 80 x 0x58. Cells 0..79 = 0x58 and cursor_pos = 80. Then send CR, BS, BS:
//     cursor_pos stays 80.
//  4. Put 0x30+r at column 0 of each row r via LF, then send LF at row 24.
//     - in_ready is low for exactly 2001 cycles.
//     - Afterwards cell 0 = 0x31, cell 1840 = 0x48, cells 1920..1999 = 0x20,
//       cursor_pos = 1920.
//  5. Send FF mid-screen. Cursor goes to 0, the screen reads all 0x20 after 2000
//     cycles, and bytes offered with in_valid held high are not accepted meanwhile.
//  6. Assert rst_n for 1 cycle at cycle 500 of a scroll. The block restarts CLEAR_ALL,
//     cursor_pos = 0, all cells end 0x20. Also check that rd_pos reads stay live
//     throughout.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants, control codes, FSM state type and cell-address helper
// for the character-cell text console.
package vga_text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 7;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'((ROWS - 1) * COLS);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ALL,
        SCROLL,
        CLEAR_ROW
    } state_e;

    // row*80 built as row*64 + row*16 so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 6) + (r << 4) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character RAM: port A has a write address plus a registered read for the writer,
// port B is a registered read-only port for the renderer.
module text_ram
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [7:0]        a_wdata,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [7:0]        a_rdata,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [7:0]        b_rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Reads return the value held before a same-edge write.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        a_rdata <= mem[a_raddr];
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/text_console.sv
// Terminal writer: decodes a byte stream into the character RAM at a hardware
// cursor, with clear, scroll and a live renderer read port.
module text_console
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_pos,
    output logic [7:0]        rd_char,
    output logic [ADDR_W-1:0] cursor_pos
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]  cursor_pos_q, cursor_pos_d;

    logic               hs;
    logic               printable;
    logic               newline;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [ADDR_W-1:0]  ram_raddr;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram_rdata;

    assign in_ready     = (state_q == IDLE);
    assign hs           = in_valid && in_ready;
    assign printable    = (in_data >= 8'h20) && (in_data != 8'h7F);
    assign cursor_pos_d = cell_addr(row_q, col_q);
    assign cursor_pos   = cursor_pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR_ALL;
            addr_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cursor_pos_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cursor_pos_q <= cursor_pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        newline = 1'b0;
        case (state_q)
            CLEAR_ALL, CLEAR_ROW: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_CELL) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            SCROLL: begin
                // The final step only writes the last copied cell; the row clear
                // then starts at the same address.
                if (addr_q == SCROLL_END) begin
                    state_d = CLEAR_ROW;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            IDLE: begin
                if (hs) begin
                    if (printable) begin
                        if (col_q == COL_W'(COLS - 1)) begin
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        case (in_data)
                            CH_LF: newline = 1'b1;
                            CH_CR: col_d = '0;
                            CH_BS: if (col_q != '0) col_d = col_q - 1'b1;
                            CH_FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                state_d = CLEAR_ALL;
                                addr_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        col_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            state_d = SCROLL;
                            addr_d  = '0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr_q;
        ram_wdata = FILL_CHAR;
        ram_raddr = addr_q + ADDR_W'(COLS);
        case (state_q)
            CLEAR_ALL, CLEAR_ROW: ram_we = 1'b1;
            SCROLL: begin
                // Data read one row below on the previous cycle lands one cell back.
                ram_we    = (addr_q != '0);
                ram_waddr = addr_q - 1'b1;
                ram_wdata = ram_rdata;
            end
            IDLE: begin
                ram_we    = hs && printable;
                ram_waddr = cell_addr(row_q, col_q);
                ram_wdata = in_data;
            end
            default: ;
        endcase
    end

    text_ram u_ram (
        .clk     (clk),
        .a_we    (ram_we),
        .a_waddr (ram_waddr),
        .a_wdata (ram_wdata),
        .a_raddr (ram_raddr),
        .a_rdata (ram_rdata),
        .b_en    (rst_n),
        .b_addr  (rd_pos),
        .b_rdata (rd_char)
    );

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a screen/cursor model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_text_console;

    localparam int NCELL = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] rd_pos = 11'd0;
    logic [7:0]  rd_char;
    logic [10:0] cursor_pos;

    text_console dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_pos     (rd_pos),
        .rd_char    (rd_char),
        .cursor_pos (cursor_pos)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl_mem [0:NCELL-1];
    int         row = 0, col = 0, busy = 0, exp_cpos = 0, sweep = 0;
    bit         op_clr = 1'b1, rd_valid = 1'b0, hs_seen = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCELL; i++) mdl_mem[i] = 8'h20;
        row = 0; col = 0; busy = 2000; op_clr = 1'b1; exp_cpos = 0; rd_valid = 1'b0;
    endtask

    task automatic model_newline();
        col = 0;
        if (row < 24) begin
            row++;
        end else begin
            for (int d = 0; d < 1920; d++) mdl_mem[d] = mdl_mem[d + 80];
            for (int d = 1920; d < NCELL; d++) mdl_mem[d] = 8'h20;
            busy = 2001;
            op_clr = 1'b0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b != 8'h7F) begin
            mdl_mem[row * 80 + col] = b;
            if (col == 79) model_newline();
            else col++;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h0D) begin
            col = 0;
        end else if (b == 8'h08) begin
            if (col > 0) col--;
        end else if (b == 8'h0C) begin
            row = 0; col = 0;
            for (int i = 0; i < NCELL; i++) mdl_mem[i] = 8'h20;
            busy = 2000;
            op_clr = 1'b1;
        end
    endtask

    // Runs just before each rising edge: check outputs, then advance the model.
    task automatic monitor_step();
        hs_seen = 1'b0;
        check("mon_in_ready", in_ready, (rst_n && busy == 0) ? 1 : 0);
        check("mon_cursor_pos", cursor_pos, rst_n ? exp_cpos : 0);
        if (rd_valid) check("mon_rd_char", rd_char, exp_rd);
        if (!rst_n) begin
            model_reset();
            return;
        end
        rd_valid = (rd_pos < 11'(NCELL)) &&
                   (busy == 0 || (op_clr && int'(rd_pos) < 2000 - busy));
        if (rd_pos < 11'(NCELL)) exp_rd = mdl_mem[rd_pos];
        exp_cpos = row * 80 + col;
        if (busy > 0) begin
            busy--;
        end else if (in_valid) begin
            hs_seen = 1'b1;
            model_byte(in_data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
        sweep = (sweep + 37) % NCELL;
        rd_pos = 11'(sweep);
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        in_data = b;
        in_valid = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!hs_seen && waited < 5000);
        in_valid = 1'b0;
        if (!hs_seen) check("handshake_timeout", 0, 1);
        $display("tx byte=%02h accepted after %0d cycles", b, waited);
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        send_byte(b, w);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!in_ready && n < 5000);
    endtask

    task automatic read_cell(input int addr, input logic [7:0] exp, input string name);
        rd_pos = 11'(addr);
        tick();
        check(name, rd_char, exp);
    endtask

    initial begin
        int n;
        // Reset and initial clear
        repeat (3) tick();
        check("reset_cursor", cursor_pos, 0);
        check("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        wait_ready(n);
        check("clear_all_cycles", n, 2000);
        read_cell(0, 8'h20, "init_cell0");
        read_cell(1999, 8'h20, "init_cell1999");
        read_cell(1024, 8'h20, "init_cell1024");

        // Plain and inverted characters
        send(8'h41);
        send(8'h42);
        read_cell(0, 8'h41, "ab_cell0");
        check("ab_cursor", cursor_pos, 2);
        read_cell(1, 8'h42, "ab_cell1");
        send(8'hC1);
        read_cell(2, 8'hC1, "inv_cell2");

        // Full row with wrap, then CR/BS at column 0 and ignored codes
        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'h58);
        read_cell(0, 8'h58, "row0_cell0");
        read_cell(79, 8'h58, "row0_cell79");
        check("wrap_cursor", cursor_pos, 80);
        send(8'h0D);
        send(8'h08);
        send(8'h08);
        tick();
        check("bs_col0_cursor", cursor_pos, 80);
        send(8'h51);
        send(8'h08);
        send(8'h7F);
        send(8'h01);
        tick();
        check("bs_mid_cursor", cursor_pos, 80);
        read_cell(80, 8'h51, "q_cell80");
        read_cell(81, 8'h20, "del_not_written");

        // Row labels then scroll
        send(8'h0C);
        wait_ready(n);
        check("ff_clear_cycles", n, 2000);
        for (int r = 0; r < 25; r++) begin
            send(8'(8'h30 + r));
            if (r < 24) send(8'h0A);
        end
        send(8'h0A);
        wait_ready(n);
        check("scroll_ready_low", n, 2001);
        read_cell(0, 8'h31, "scroll_cell0");
        read_cell(1840, 8'h48, "scroll_cell1840");
        read_cell(1920, 8'h20, "scroll_cell1920");
        read_cell(1999, 8'h20, "scroll_cell1999");
        check("scroll_cursor", cursor_pos, 1920);

        // Form feed mid-screen with a byte held valid during the clear
        send(8'h6B);
        send(8'h0C);
        send_byte(8'h5A, n);
        check("ff_hold_wait", n, 2001);
        read_cell(0, 8'h5A, "ff_cell0");
        check("ff_cursor", cursor_pos, 1);
        read_cell(1921, 8'h20, "ff_cell1921");
        read_cell(1999, 8'h20, "ff_cell1999");

        // Reset in the middle of a scroll
        for (int r = 0; r < 24; r++) send(8'h0A);
        send(8'h0A);
        repeat (500) tick();
        check("midscroll_busy", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("abort_clear_cycles", n, 2000);
        check("abort_cursor", cursor_pos, 0);
        read_cell(0, 8'h20, "abort_cell0");
        read_cell(1840, 8'h20, "abort_cell1840");
        read_cell(1999, 8'h20, "abort_cell1999");
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
